// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing, command bytes and scan codes.
// Imported by the host transmitter and reusable by the receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERR_TO,
    ST_ERR_NACK
  } state_t;

  // Default timing at 50 MHz
  localparam int DEF_CLK_HOLD_CYCLES      = 6000;
  localparam int DEF_START_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FRAME_TIMEOUT_CYCLES = 100000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ACK      = 8'hFA;

  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_RELEASE = 8'hF0;
  localparam logic [7:0] SC_L       = 8'h4B;
  localparam logic [7:0] SC_B       = 8'h32;
  localparam logic [7:0] SC_M       = 8'h3A;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter: request strobe and byte in, status pulses out.
// No backpressure beyond busy; a request seen while busy is simply dropped.
interface ps2_host_tx_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       command_was_sent;
  logic       ack_error;
  logic       error_communication_timed_out;

  modport master (
    output the_command, send_command,
    input  busy, command_was_sent, ack_error, error_communication_timed_out
  );

  modport slave (
    input  the_command, send_command,
    output busy, command_was_sent, ack_error, error_communication_timed_out
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a registered falling-edge strobe on the clock.
// Pin edge to fall strobe is 3 cycles; no backpressure.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_s,
  output logic dat_s,
  output logic fall
);
  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_d;

  // Idle bus is high, so the flops reset to 1 to avoid a spurious edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff <= 2'b11;
      dat_ff <= 2'b11;
      clk_d  <= 1'b1;
      fall   <= 1'b0;
    end else begin
      clk_ff <= {clk_ff[0], ps2_clk};
      dat_ff <= {dat_ff[0], ps2_dat};
      clk_d  <= clk_ff[1];
      fall   <= clk_d & ~clk_ff[1];
    end
  end

  assign clk_s = clk_ff[1];
  assign dat_s = dat_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift d0..d7/parity/stop on device clocks, check ACK.
// busy rises the cycle after acceptance; requests while busy are ignored; all outputs registered.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HOLD_CYCLES      = DEF_CLK_HOLD_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int FRAME_TIMEOUT_CYCLES = DEF_FRAME_TIMEOUT_CYCLES
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave host,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DAT
);
  localparam int HOLD_W = $clog2(CLK_HOLD_CYCLES + 1);
  localparam int TO_MAX = (START_TIMEOUT_CYCLES > FRAME_TIMEOUT_CYCLES) ?
                          START_TIMEOUT_CYCLES : FRAME_TIMEOUT_CYCLES;
  localparam int TO_W   = $clog2(TO_MAX + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(CLK_HOLD_CYCLES);
  localparam logic [TO_W-1:0]   START_LAST = TO_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   FRAME_LAST = TO_W'(FRAME_TIMEOUT_CYCLES - 1);

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [9:0]        shreg, shreg_n;
  logic              clk_oe, clk_oe_n;
  logic              dat_oe, dat_oe_n;
  logic              busy_q, busy_n;
  logic              sent_q, sent_n;
  logic              nack_q, nack_n;
  logic              tout_q, tout_n;
  logic              clk_s, dat_s, fall;

  ps2_line_sync u_sync (
    .clk     (CLOCK_50),
    .rst     (reset),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    to_cnt_n   = to_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    clk_oe_n   = clk_oe;
    dat_oe_n   = dat_oe;
    sent_n     = 1'b0;
    nack_n     = 1'b0;
    tout_n     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (host.send_command) begin
          state_n    = ST_INHIBIT;
          // Frame bits leave LSB first: d0..d7, parity, stop
          shreg_n    = {1'b1, odd_parity(host.the_command), host.the_command};
          bit_cnt_n  = '0;
          to_cnt_n   = '0;
          hold_cnt_n = HOLD_W'(1);
          clk_oe_n   = 1'b1;
          dat_oe_n   = (HOLD_LAST == HOLD_W'(1));
        end
      end

      ST_INHIBIT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n  = ST_RTS;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
          clk_oe_n   = 1'b1;
          dat_oe_n   = ((hold_cnt + HOLD_W'(1)) == HOLD_LAST);
        end
      end

      ST_RTS: begin
        if (to_cnt == START_LAST) begin
          state_n  = ST_ERR_TO;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
        end else if (fall) begin
          state_n   = ST_DATA;
          to_cnt_n  = '0;
          dat_oe_n  = ~shreg[0];
          shreg_n   = {1'b1, shreg[9:1]};
          bit_cnt_n = bit_cnt + 4'd1;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end

      ST_DATA: begin
        if (to_cnt == FRAME_LAST) begin
          state_n  = ST_ERR_TO;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
          if (fall) begin
            dat_oe_n  = ~shreg[0];
            shreg_n   = {1'b1, shreg[9:1]};
            bit_cnt_n = bit_cnt + 4'd1;
            // Ninth bit index is the stop bit, which releases the line
            if (bit_cnt == 4'd9) state_n = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (to_cnt == FRAME_LAST) begin
          state_n  = ST_ERR_TO;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
          if (fall) state_n = dat_s ? ST_ERR_NACK : ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (to_cnt == FRAME_LAST) begin
          state_n  = ST_ERR_TO;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
          if (clk_s && dat_s) begin
            state_n = ST_IDLE;
            sent_n  = 1'b1;
          end
        end
      end

      ST_ERR_TO: begin
        state_n  = ST_IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        tout_n   = 1'b1;
      end

      ST_ERR_NACK: begin
        state_n  = ST_IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        nack_n   = 1'b1;
      end

      default: begin
        state_n  = ST_IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
      end
    endcase

    // Registered busy drops together with the completion pulse
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      clk_oe   <= 1'b0;
      dat_oe   <= 1'b0;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
      nack_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      to_cnt   <= to_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      clk_oe   <= clk_oe_n;
      dat_oe   <= dat_oe_n;
      busy_q   <= busy_n;
      sent_q   <= sent_n;
      nack_q   <= nack_n;
      tout_q   <= tout_n;
    end
  end

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  assign host.busy                          = busy_q;
  assign host.command_was_sent              = sent_q;
  assign host.ack_error                     = nack_q;
  assign host.error_communication_timed_out = tout_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with pull-ups and a behavioural keyboard clocking at 40 cycles/period.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wire  ps2_clk;
  wire  ps2_dat;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_host_tx_if h ();

  ps2_host_tx #(
    .CLK_HOLD_CYCLES      (50),
    .START_TIMEOUT_CYCLES (2000),
    .FRAME_TIMEOUT_CYCLES (4000)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .host     (h),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat)
  );

  int tests  = 0;
  int failed = 0;

  int   n_sent = 0, n_nack = 0, n_tout = 0, n_busy_bad = 0, n_wide = 0;
  logic p_sent = 1'b0, p_nack = 1'b0, p_tout = 1'b0;

  always @(negedge clk) begin
    if (h.command_was_sent) n_sent++;
    if (h.ack_error) n_nack++;
    if (h.error_communication_timed_out) n_tout++;
    if ((h.command_was_sent || h.ack_error || h.error_communication_timed_out) && h.busy)
      n_busy_bad++;
    if ((h.command_was_sent && p_sent) || (h.ack_error && p_nack) ||
        (h.error_communication_timed_out && p_tout))
      n_wide++;
    p_sent = h.command_was_sent;
    p_nack = h.ack_error;
    p_tout = h.error_communication_timed_out;
  end

  typedef struct {
    logic [7:0] cmd;
    logic       ack_ok;
    logic [9:0] exp_bits;  // {stop, parity, d7..d0}
    int         exp_sent;
    int         exp_nack;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Odd parity from the definition: parity bit makes the total count of ones odd
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    ones = $countones(b);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic send_cmd(input logic [7:0] c, input string tag);
    @(negedge clk);
    check({tag, "_busy_before"}, h.busy, 1'b0);
    h.the_command  = c;
    h.send_command = 1'b1;
    @(posedge clk);
    #1;
    h.send_command = 1'b0;
    check({tag, "_busy_rise"}, h.busy, 1'b1);
    check({tag, "_clk_low_at_accept"}, ps2_clk, 1'b0);
  endtask

  task automatic watch_rts(output int hold, output int dlow, output logic rel_dat);
    hold = 0;
    dlow = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ps2_clk !== 1'b0) break;
      hold++;
      if (ps2_dat === 1'b0) dlow++;
    end
    rel_dat = ps2_dat;
  endtask

  task automatic dev_clocks(input int nfall, input logic ack_ok,
                            output logic [9:0] bits, output logic start);
    bits = '0;
    repeat (10) @(negedge clk);
    start = ps2_dat;
    for (int i = 0; i < nfall; i++) begin
      if (i == 10 && ack_ok) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (i < 10) bits[i] = ps2_dat;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (h.busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_in_time"}, h.busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int         s0, n0, t0, hold, dlow;
    logic       start, rel_dat;
    logic [9:0] bits;
    s0 = n_sent;
    n0 = n_nack;
    t0 = n_tout;
    send_cmd(v.cmd, tag);
    watch_rts(hold, dlow, rel_dat);
    check({tag, "_clk_hold"}, hold, 50);
    check({tag, "_dat_lead"}, dlow, 1);
    check({tag, "_dat_at_release"}, rel_dat, 1'b0);
    dev_clocks(11, v.ack_ok, bits, start);
    check({tag, "_start_bit"}, start, 1'b0);
    check({tag, "_bits"}, bits, v.exp_bits);
    wait_done(tag);
    check({tag, "_sent_pulses"}, n_sent - s0, v.exp_sent);
    check({tag, "_nack_pulses"}, n_nack - n0, v.exp_nack);
    check({tag, "_timeout_pulses"}, n_tout - t0, 0);
    check({tag, "_clk_released"}, ps2_clk, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    int         s0, n0, t0, hold, dlow, k;
    logic       start, rel_dat;
    logic [9:0] bits;

    vecs[0] = '{cmd: CMD_SET_LEDS, ack_ok: 1'b1, exp_bits: 10'h3ED, exp_sent: 1, exp_nack: 0};
    vecs[1] = '{cmd: 8'h01,        ack_ok: 1'b1, exp_bits: 10'h201, exp_sent: 1, exp_nack: 0};
    vecs[2] = '{cmd: 8'hFF,        ack_ok: 1'b1, exp_bits: 10'h3FF, exp_sent: 1, exp_nack: 0};
    vecs[3] = '{cmd: 8'hED,        ack_ok: 1'b0, exp_bits: 10'h3ED, exp_sent: 0, exp_nack: 1};
    vecs[4] = '{cmd: 8'h5A,        ack_ok: 1'b1, exp_bits: 10'h35A, exp_sent: 1, exp_nack: 0};

    h.the_command  = 8'h00;
    h.send_command = 1'b0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_clk_released", ps2_clk, 1'b1);
    check("reset_dat_released", ps2_dat, 1'b1);
    check("reset_busy", h.busy, 1'b0);
    check("reset_sent", h.command_was_sent, 1'b0);
    check("reset_nack", h.ack_error, 1'b0);
    check("reset_timeout", h.error_communication_timed_out, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      v.cmd      = 8'($urandom_range(0, 255));
      v.ack_ok   = ($urandom_range(0, 3) != 0);
      v.exp_bits = ref_frame(v.cmd);
      v.exp_sent = v.ack_ok ? 1 : 0;
      v.exp_nack = v.ack_ok ? 0 : 1;
      do_vec(v, $sformatf("rand%0d_%02h", r, v.cmd));
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // Device never clocks after request-to-send
    s0 = n_sent;
    t0 = n_tout;
    send_cmd(8'hA5, "tout");
    watch_rts(hold, dlow, rel_dat);
    check("tout_clk_hold", hold, 50);
    k = 0;
    while (!h.error_communication_timed_out && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("tout_delay_near_2000", (k >= 1996 && k <= 2005), 1'b1);
    check("tout_clk_released", ps2_clk, 1'b1);
    check("tout_dat_released", ps2_dat, 1'b1);
    check("tout_busy_low", h.busy, 1'b0);
    repeat (3) @(negedge clk);
    check("tout_pulses", n_tout - t0, 1);
    check("tout_no_sent", n_sent - s0, 0);

    // Reset after the 4th falling edge aborts the frame
    s0 = n_sent;
    n0 = n_nack;
    t0 = n_tout;
    send_cmd(8'h00, "abort");
    watch_rts(hold, dlow, rel_dat);
    dev_clocks(4, 1'b0, bits, start);
    check("abort_bits_so_far", bits[3:0], 4'h0);
    check("abort_dat_driven", ps2_dat, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_clk_released", ps2_clk, 1'b1);
    check("abort_dat_released", ps2_dat, 1'b1);
    check("abort_busy_low", h.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_sent", n_sent - s0, 0);
    check("abort_no_nack", n_nack - n0, 0);
    check("abort_no_timeout", n_tout - t0, 0);
    v = '{cmd: 8'h00, ack_ok: 1'b1, exp_bits: 10'h300, exp_sent: 1, exp_nack: 0};
    do_vec(v, "after_abort");

    // A request while busy must not disturb the frame or queue a second one
    s0 = n_sent;
    send_cmd(CMD_SET_LEDS, "overlap");
    watch_rts(hold, dlow, rel_dat);
    fork
      dev_clocks(11, 1'b1, bits, start);
      begin
        repeat (150) @(negedge clk);
        h.the_command  = 8'h55;
        h.send_command = 1'b1;
        @(negedge clk);
        h.send_command = 1'b0;
      end
    join
    check("overlap_bits", bits, 10'h3ED);
    wait_done("overlap");
    repeat (100) @(negedge clk);
    check("overlap_sent_once", n_sent - s0, 1);
    check("overlap_no_restart_busy", h.busy, 1'b0);
    check("overlap_no_restart_clk", ps2_clk, 1'b1);

    check("pulse_with_busy_high", n_busy_bad, 0);
    check("pulse_wider_than_one", n_wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte from the FPGA to the keyboard, for example `0xED` followed by an LED mask to mirror mode state on the keyboard LEDs. It implements the host side of the bidirectional PS/2 link:
- inhibit the clock, issue a request-to-send, shift out the frame on device-generated clocks, then check the device ACK bit.
- It sits beside the existing PS/2 receive path on the same `PS2_CLK`/`PS2_DAT` pins and drives that path's `the_command`/`send_command` side.

## Interface
Parameters:
- `CLK_HOLD_CYCLES`, 6000: cycles `PS2_CLK` is held low for the request-to-send (120 µs at 50 MHz).
- `START_TIMEOUT_CYCLES`, 750000: maximum wait from clock release to the first device falling edge (15 ms).
- `FRAME_TIMEOUT_CYCLES`, 100000: maximum time from the first device falling edge to ACK sampled (2 ms).

Ports:
- `CLOCK_50`  in  1  sole clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `the_command`  in  8  byte to send; sampled only on an accepted request.
- `send_command`  in  1  request strobe; accepted only when `busy`=0.
- `PS2_CLK`  inout  1  open-drain: driven 0 or released (Z), never driven 1.
- `PS2_DAT`  inout  1  open-drain: same rule as `PS2_CLK`.
- `busy`  out  1  high from acceptance until return to IDLE.
- `command_was_sent`  out  1  one-cycle pulse on a successful, ACKed transfer.
- `ack_error`  out  1  one-cycle pulse when the device NACKs (data high at the ACK edge).
- `error_communication_timed_out`  out  1  one-cycle pulse on either timeout.

## Operation
- `PS2_CLK` and `PS2_DAT` pass through 2-FF synchronizers; a falling edge of the synchronized clock produces a one-cycle `fall` strobe.
- On acceptance:
  - latch the byte into a shift register;
  - compute odd parity (parity = ~^byte);
  - clear the bit counter and the timeout counter.
- States:
  - IDLE: both lines released. `send_command`=1 → INHIBIT.
  - INHIBIT: drive `PS2_CLK`=0 for `CLK_HOLD_CYCLES`. In the last hold cycle also drive `PS2_DAT`=0 (start bit), then → RTS.
  - RTS: release `PS2_CLK` and keep `PS2_DAT`=0. First `fall` → DATA. Counter reaching `START_TIMEOUT_CYCLES` → ERR_TO.
  - DATA: on each `fall`, drive the next bit onto `PS2_DAT` (0 → drive low, 1 → release). Order is d0..d7, then parity, then stop (release). After the stop bit → ACK.
  - ACK: on the next `fall`, sample synchronized `PS2_DAT`. 0 → WAIT_IDLE; 1 → ERR_NACK.
  - WAIT_IDLE: wait until both synchronized lines are 1, then pulse `command_was_sent` → IDLE.
  - ERR_TO / ERR_NACK: release both lines, pulse the matching error output for one cycle → IDLE.
- The frame timeout runs from the first `fall` through ACK sampling. Exceeding `FRAME_TIMEOUT_CYCLES` from DATA, ACK or WAIT_IDLE → ERR_TO.
- `send_command` is ignored while `busy`; there is no queueing.
- Asynchronous reset:
  - releases both lines immediately and returns to IDLE;
  - clears `busy` and all pulses;
  - aborts any in-flight frame. The device recovers via its own timeout.
- Reset values: `PS2_CLK`=Z, `PS2_DAT`=Z, `busy`=0, `command_was_sent`=0, `ack_error`=0, `error_communication_timed_out`=0.

## Timing
- `busy` rises the cycle after `send_command` is accepted. `PS2_CLK` is driven low in that same cycle.
- `PS2_CLK` is low for exactly `CLK_HOLD_CYCLES` cycles. `PS2_DAT` goes low one cycle before `PS2_CLK` is released.
- Pin-edge to `fall` latency is 3 cycles (2 sync + 1 edge detect). The data update follows one cycle later. This is well inside the ≥5 µs device clock-low phase.
- Falling-edge count per frame is fixed at 11: d0–d7, parity, stop, ACK.
- Pulse outputs are high for exactly one cycle. `busy` falls in the same cycle as the pulse.
- A timeout and a `fall` in the same cycle: the timeout wins.

## Structure
- Package `ps2_pkg`:
  - state enum;
  - default timing constants;
  - PS/2 command bytes: SET_LEDS=`0xED`, RESET=`0xFF`, ACK=`0xFA`;
  - shared scan-code constants: ENTER=`0x5A`, RELEASE=`0xF0`, L=`0x4B`, B=`0x32`, M=`0x3A`.
- Sub-module `ps2_line_sync`: 2-FF synchronizer for both lines plus clock falling-edge detect. It is reusable by the receive path.
- Tristate drivers live in the top: `PS2_CLK = clk_oe ? 1'b0 : 1'bz`, and likewise for `PS2_DAT`.

## Test plan
Simulation overrides `CLK_HOLD_CYCLES`=50, `START_TIMEOUT_CYCLES`=2000, `FRAME_TIMEOUT_CYCLES`=4000. The bench models the device clock at 40 cycles per period.
- Send `0xED`, device ACKs → `PS2_CLK` low for 50 cycles. Bits sampled at device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1. `command_was_sent` pulses once and `busy` falls.
- Send `0x01`, then `0xFF` → parity bits 0 and 1 respectively. Both transfers ACKed.
- Device never clocks after request-to-send → `error_communication_timed_out` pulses 2000 cycles after clock release. Both lines Z.
- Device holds `PS2_DAT` high at the 11th falling edge → `ack_error` pulses; `command_was_sent` stays 0.
- Assert `reset` after the 4th falling edge → both lines Z and `busy`=0 in the same cycle, with no pulses. A following `0x00` request completes normally.
- Pulse `send_command` with `0x55` while `busy` during an `0xED` frame → the `0xED` bits are unchanged and exactly one `command_was_sent` pulse occurs.
